// File: rtl/lvds_serializer_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lvds_pkg
// Description : Shared definitions for the LVDS transmit serializer family:
//               serializer state encoding, bit-counter width helper and the
//               default frame width / idle line level.
// Ports       : none (package)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package lvds_pkg;

    localparam int LVDS_DATA_W     = 5;
    localparam bit LVDS_IDLE_LEVEL = 1'b0;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // Bit-counter width for a frame of data_w bits. A 2-bit frame still
    // needs a 1-bit counter, so the result is never below 1.
    function automatic int cnt_w(input int data_w);
        return (data_w <= 2) ? 1 : $clog2(data_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_serializer_param_if.sv
`default_nettype none
// ============================================================================
// Module      : lvds_serializer_param_if
// Description : Parallel-in / serial-out bundle of the LVDS serializer.
// Ports       : data_i, valid_i       - parallel word handshake (upstream)
//               ready_o               - serializer can take a word
//               serial_o, lvds_busy   - serial line and frame-in-flight flag
//               frame_done_o          - pulse on the last bit of a frame
//               master modport: upstream side; slave modport: serializer
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface lvds_serializer_param_if
    import lvds_pkg::*;
#(
    parameter int DATA_W = LVDS_DATA_W
);

    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic              serial_o;
    logic              lvds_busy;
    logic              frame_done_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  serial_o,
        input  lvds_busy,
        input  frame_done_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output serial_o,
        output lvds_busy,
        output frame_done_o
    );

endinterface
`default_nettype wire

// File: rtl/lvds_serializer_param_ser_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : ser_hold_reg
// Description : One-entry valid/ready holding register in front of a
//               consumer. When the consumer asks for a word (take_i) and the
//               register is empty, an incoming word bypasses it.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               data_i, valid_i      - upstream word and valid
//               take_i               - consumer loads a word at this edge
//               ready_o              - register empty (registered)
//               drain_o              - consumer loads the held word
//               bypass_o             - consumer loads data_i directly
//               hold_o               - held word
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module ser_hold_reg #(
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              take_i,
    output logic              ready_o,
    output logic              drain_o,
    output logic              bypass_o,
    output logic [DATA_W-1:0] hold_o
);

    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;
    logic              hold_v_q;
    logic              hold_v_d;
    logic              w_accept;
    logic              w_fill;

    assign ready_o  = ~hold_v_q;
    assign w_accept = valid_i & ~hold_v_q;
    assign drain_o  = take_i & hold_v_q;
    assign bypass_o = take_i & w_accept;
    // A word is parked only when the consumer is not taking it directly.
    assign w_fill   = w_accept & ~take_i;
    assign hold_o   = hold_q;

    always_comb begin
        hold_v_d = (hold_v_q & ~drain_o) | w_fill;
        hold_d   = w_fill ? data_i : hold_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lvds_serializer_param.sv
`default_nettype none
// ============================================================================
// Module      : lvds_serializer_param
// Description : Parametrised frame serializer for the LVDS transmit path.
//               Words arrive over valid/ready and leave one bit per clock on
//               serial_o; a one-entry holding register allows back-to-back
//               frames with no idle bit in between.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               bus (slave) - data_i/valid_i/ready_o handshake,
//                             serial_o, lvds_busy, frame_done_o
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module lvds_serializer_param
    import lvds_pkg::*;
#(
    parameter int DATA_W     = LVDS_DATA_W,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = LVDS_IDLE_LEVEL
) (
    input logic                    clk,
    input logic                    reset,
    lvds_serializer_param_if.slave bus
);

    localparam int               CNT_W     = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [0:0]       ST_IDLE   = SER_IDLE;
    localparam logic [0:0]       ST_SHIFT  = SER_SHIFT;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_d;

    logic              w_last;
    logic              w_take;
    logic              w_ready;
    logic              w_drain;
    logic              w_bypass;
    logic [DATA_W-1:0] w_hold_word;
    logic [DATA_W-1:0] w_shifted;
    logic              w_head;

    assign w_last = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
    // The shifter can take a new word when idle or while its last bit is out,
    // which is what makes consecutive frames seamless.
    assign w_take = (state_q == ST_IDLE) || w_last;

    ser_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .data_i   (bus.data_i),
        .valid_i  (bus.valid_i),
        .take_i   (w_take),
        .ready_o  (w_ready),
        .drain_o  (w_drain),
        .bypass_o (w_bypass),
        .hold_o   (w_hold_word)
    );

    if (MSB_FIRST) begin : g_msb_first
        assign w_head    = shift_q[DATA_W-1];
        assign w_shifted = {shift_q[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
        assign w_head    = shift_q[0];
        assign w_shifted = {1'b0, shift_q[DATA_W-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (w_drain || w_bypass) begin
            state_d   = ST_SHIFT;
            shift_d   = w_bypass ? bus.data_i : w_hold_word;
            bit_cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            shift_d = w_shifted;
            if (w_last) begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Every output is a decode of registered state only.
    assign bus.ready_o      = w_ready;
    assign bus.lvds_busy    = (state_q == ST_SHIFT);
    assign bus.serial_o     = (state_q == ST_SHIFT) ? w_head : IDLE_LEVEL;
    assign bus.frame_done_o = w_last;

endmodule
`default_nettype wire

// File: tb/tb_lvds_serializer_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_lvds_serializer_param
// Description : Self-checking bench for lvds_serializer_param. Three
//               instances: (5, MSB first, idle 0), (5, LSB first, idle 0),
//               (32, MSB first, idle 1), each checked every cycle against a
//               frame/queue model, plus literal expectations per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lvds_serializer_param;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        vld   [3];
    logic [31:0] din   [3];
    logic        ser_o [3];
    logic        bsy_o [3];
    logic        dne_o [3];
    logic        rdy_o [3];

    always #5 clk = ~clk;

    lvds_serializer_param_if #(.DATA_W(5))  bus0 ();
    lvds_serializer_param_if #(.DATA_W(5))  bus1 ();
    lvds_serializer_param_if #(.DATA_W(32)) bus2 ();

    assign bus0.data_i  = din[0][4:0];
    assign bus0.valid_i = vld[0];
    assign bus1.data_i  = din[1][4:0];
    assign bus1.valid_i = vld[1];
    assign bus2.data_i  = din[2];
    assign bus2.valid_i = vld[2];

    assign ser_o[0] = bus0.serial_o;  assign bsy_o[0] = bus0.lvds_busy;
    assign dne_o[0] = bus0.frame_done_o; assign rdy_o[0] = bus0.ready_o;
    assign ser_o[1] = bus1.serial_o;  assign bsy_o[1] = bus1.lvds_busy;
    assign dne_o[1] = bus1.frame_done_o; assign rdy_o[1] = bus1.ready_o;
    assign ser_o[2] = bus2.serial_o;  assign bsy_o[2] = bus2.lvds_busy;
    assign dne_o[2] = bus2.frame_done_o; assign rdy_o[2] = bus2.ready_o;

    lvds_serializer_param #(.DATA_W(5), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0))
        u_dut0 (.clk(clk), .reset(rst[0]), .bus(bus0));
    lvds_serializer_param #(.DATA_W(5), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0))
        u_dut1 (.clk(clk), .reset(rst[1]), .bus(bus1));
    lvds_serializer_param #(.DATA_W(32), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1))
        u_dut2 (.clk(clk), .reset(rst[2]), .bus(bus2));

    // Per-instance configuration seen by the model.
    int wk   [3];
    bit msbk [3];
    bit idlk [3];

    // Model: words accepted but not yet started, current frame, bit index
    // within the frame (-1 = line idle).
    logic [31:0] pend [3][$];
    logic [31:0] cur  [3];
    int          pos  [3];

    // Observation logs (shift registers, newest bit in bit 0).
    logic [63:0] lg   [3];
    logic [63:0] dl   [3];
    int          bcnt [3];
    int          runs [3];
    bit          pb   [3];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual %0h required %0h", nm, k, act, exp);
        end
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                pend[k].delete();
                pos[k] = -1;
            end else begin
                logic [63:0] msk = (64'd1 << wk[k]) - 64'd1;
                if (vld[k] && (pend[k].size() == 0))
                    pend[k].push_back(din[k] & msk[31:0]);
                if (pos[k] == -1 || pos[k] == wk[k] - 1) begin
                    if (pend[k].size() > 0) begin
                        cur[k] = pend[k].pop_front();
                        pos[k] = 0;
                    end else begin
                        pos[k] = -1;
                    end
                end else begin
                    pos[k]++;
                end
            end
        end
    endfunction

    function automatic void compare_all();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] c = cur[k];
            bit eb = (pos[k] >= 0);
            bit es = idlk[k];
            if (eb) es = c[msbk[k] ? (wk[k] - 1 - pos[k]) : pos[k]];
            chk("serial_o", k, 64'(ser_o[k]), 64'(es));
            chk("lvds_busy", k, 64'(bsy_o[k]), 64'(eb));
            chk("frame_done_o", k, 64'(dne_o[k]), 64'(pos[k] == wk[k] - 1));
            chk("ready_o", k, 64'(rdy_o[k]), 64'(pend[k].size() == 0));
        end
    endfunction

    function automatic void log_all();
        for (int k = 0; k < 3; k++) begin
            if (bsy_o[k] === 1'b1) begin
                lg[k] = {lg[k][62:0], ser_o[k]};
                dl[k] = {dl[k][62:0], dne_o[k]};
                bcnt[k]++;
                if (!pb[k]) runs[k]++;
            end
            pb[k] = (bsy_o[k] === 1'b1);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        log_all();
    endtask

    // Present a word and hold it until the edge it is accepted at; valid is
    // left high so calls can be chained back to back.
    task automatic send(input int k, input logic [31:0] w, output int n);
        bit acc;
        vld[k] = 1'b1;
        din[k] = w;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            acc = (rdy_o[k] === 1'b1);
            tick();
            n++;
        end
        if (!acc) chk("send_timeout", k, 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (bsy_o[k] === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("idle_timeout", k, 64'd0, 64'd1);
    endtask

    initial begin
        int b0, r0, nw;
        wk   = '{5, 5, 32};
        msbk = '{1'b1, 1'b0, 1'b1};
        idlk = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; vld[k] = 1'b0; din[k] = '0;
            pos[k] = -1; cur[k] = '0; lg[k] = '0; dl[k] = '0;
            bcnt[k] = 0; runs[k] = 0; pb[k] = 1'b0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        tick();

        // Reset state
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", k, 64'(rdy_o[k]), 64'd1);
            chk("rst_busy", k, 64'(bsy_o[k]), 64'd0);
            chk("rst_done", k, 64'(dne_o[k]), 64'd0);
        end
        chk("rst_idle_line", 0, 64'(ser_o[0]), 64'd0);
        chk("rst_idle_line", 2, 64'(ser_o[2]), 64'd1);

        // Single word, MSB first
        b0 = bcnt[0]; r0 = runs[0];
        send(0, 32'b10110, nw);
        vld[0] = 1'b0;
        wait_idle(0);
        chk("single_bits", 0, 64'(lg[0][4:0]), 64'b10110);
        chk("single_done", 0, 64'(dl[0][4:0]), 64'b00001);
        chk("single_busy_cycles", 0, 64'(bcnt[0] - b0), 64'd5);
        chk("single_runs", 0, 64'(runs[0] - r0), 64'd1);
        chk("single_after", 0, 64'(ser_o[0]), 64'd0);

        // Single word, LSB first
        b0 = bcnt[1];
        send(1, 32'b10110, nw);
        vld[1] = 1'b0;
        wait_idle(1);
        chk("lsb_bits", 1, 64'(lg[1][4:0]), 64'b01101);
        chk("lsb_busy_cycles", 1, 64'(bcnt[1] - b0), 64'd5);

        // Streaming with valid held high
        b0 = bcnt[0]; r0 = runs[0];
        send(0, 32'h1F, nw);
        send(0, 32'h00, nw);
        send(0, 32'h15, nw);
        vld[0] = 1'b0;
        wait_idle(0);
        chk("stream_bits", 0, 64'(lg[0][14:0]), 64'b11111_00000_10101);
        chk("stream_done", 0, 64'(dl[0][14:0]), 64'b00001_00001_00001);
        chk("stream_busy_cycles", 0, 64'(bcnt[0] - b0), 64'd15);
        chk("stream_runs", 0, 64'(runs[0] - r0), 64'd1);

        // Backpressure: three words offered while the shifter is busy
        b0 = bcnt[0]; r0 = runs[0];
        send(0, 32'h1C, nw);
        send(0, 32'h0A, nw);
        chk("bp_ready_low", 0, 64'(rdy_o[0]), 64'd0);
        send(0, 32'h13, nw);
        chk("bp_wait_ticks", 0, 64'(nw), 64'd5);
        send(0, 32'h07, nw);
        vld[0] = 1'b0;
        wait_idle(0);
        chk("bp_bits", 0, 64'(lg[0][19:0]), 64'b11100_01010_10011_00111);
        chk("bp_done", 0, 64'(dl[0][19:0]), 64'b00001_00001_00001_00001);
        chk("bp_busy_cycles", 0, 64'(bcnt[0] - b0), 64'd20);
        chk("bp_runs", 0, 64'(runs[0] - r0), 64'd1);

        // Reset on bit 3 with the holding register full
        send(0, 32'h16, nw);
        send(0, 32'h0B, nw);
        vld[0] = 1'b0;
        chk("rstmid_hold_full", 0, 64'(rdy_o[0]), 64'd0);
        tick();
        tick();
        chk("rstmid_bit3", 0, 64'(ser_o[0]), 64'd1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("rstmid_line", 0, 64'(ser_o[0]), 64'd0);
        chk("rstmid_busy", 0, 64'(bsy_o[0]), 64'd0);
        chk("rstmid_ready", 0, 64'(rdy_o[0]), 64'd1);
        b0 = bcnt[0];
        for (int i = 0; i < 15; i++) tick();
        chk("rstmid_no_bits", 0, 64'(bcnt[0] - b0), 64'd0);

        // 32-bit frames back to back, idle level 1
        chk("w32_idle", 2, 64'(ser_o[2]), 64'd1);
        b0 = bcnt[2]; r0 = runs[2];
        send(2, 32'hA5A5_0F0F, nw);
        send(2, 32'h3C3C_F0F0, nw);
        vld[2] = 1'b0;
        wait_idle(2);
        chk("w32_bits", 2, lg[2], 64'hA5A5_0F0F_3C3C_F0F0);
        chk("w32_done", 2, dl[2], 64'h0000_0001_0000_0001);
        chk("w32_busy_cycles", 2, 64'(bcnt[2] - b0), 64'd64);
        chk("w32_runs", 2, 64'(runs[2] - r0), 64'd1);
        chk("w32_after", 2, 64'(ser_o[2]), 64'd1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
